// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter
//   Two-port writeback arbiter in front of a single register-file write port.
//   Port 0 (main pipeline) has priority; port 1 (multi-cycle unit) is forced
//   to win once it has waited STARVE_MAX consecutive cycles. The grant is
//   combinational and the register-file write is registered (latency 1).
//
//   Optional build macro: GRF_WB_TRACE_EN -- when defined, every cycle with
//   grf_we high prints "@<pc hex8>: $<addr dec2> <= <data hex8>" in simulation.
//
// Ports
//   clk                      clock, all state changes on posedge
//   reset                    asynchronous, active-low reset
//   req0/req1                writeback request, held with payload until ack
//   addr0/addr1 [4:0]        destination register
//   data0/data1 [31:0]       write data
//   pc0/pc1 [31:0]           PC of the writing instruction
//   ack0/ack1                combinational grant (request consumed this cycle)
//   stall0                   req0 && !ack0, freezes the main pipeline
//   grf_we/grf_waddr/grf_wdata/grf_wpc   registered register-file write port
module grf_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [4:0]  addr0,
  input  logic [4:0]  addr1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] pc0,
  input  logic [31:0] pc1,
  output logic        ack0,
  output logic        ack1,
  output logic        stall0,
  output logic        grf_we,
  output logic [4:0]  grf_waddr,
  output logic [31:0] grf_wdata,
  output logic [31:0] grf_wpc
);

  localparam int            CW       = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] waitCnt_r;
  logic [CW-1:0] waitCntNext_s;
  logic          grant0_s;
  logic          grant1_s;
  logic [4:0]    selAddr_s;
  logic [31:0]   selData_s;
  logic [31:0]   selPc_s;

  // Grant decision: starved port 1 first, then port 0, then port 1; nothing in reset
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!reset) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req1 && (waitCnt_r == WAIT_LIM)) begin
      grant1_s = 1'b1;
    end else if (req0) begin
      grant0_s = 1'b1;
    end else if (req1) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign ack0   = grant0_s;
  assign ack1   = grant1_s;
  assign stall0 = req0 & ~grant0_s;

  // Starvation counter: counts consecutive losing cycles of port 1, saturating
  always_comb begin
    waitCntNext_s = {CW{1'b0}};
    if (req1 && !grant1_s) begin
      if (waitCnt_r == WAIT_LIM) begin
        waitCntNext_s = waitCnt_r;
      end else begin
        waitCntNext_s = waitCnt_r + CW'(1);
      end
    end else begin
      waitCntNext_s = {CW{1'b0}};
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt_r <= {CW{1'b0}};
    end else begin
      waitCnt_r <= waitCntNext_s;
    end
  end

  // Payload mux follows the granted port
  always_comb begin
    selAddr_s = addr0;
    selData_s = data0;
    selPc_s   = pc0;
    if (grant1_s) begin
      selAddr_s = addr1;
      selData_s = data1;
      selPc_s   = pc1;
    end else begin
      selAddr_s = addr0;
      selData_s = data0;
      selPc_s   = pc0;
    end
  end

  // Write stage: capture on grant; writes to $0 are acked but never enabled.
  // Reset clears a captured entry so no write appears after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we    <= 1'b0;
      grf_waddr <= 5'd0;
      grf_wdata <= 32'd0;
      grf_wpc   <= 32'd0;
    end else if (grant0_s || grant1_s) begin
      grf_we    <= (selAddr_s != 5'd0);
      grf_waddr <= selAddr_s;
      grf_wdata <= selData_s;
      grf_wpc   <= selPc_s;
    end else begin
      grf_we    <= 1'b0;
    end
  end

`ifdef GRF_WB_TRACE_EN
  // Simulation trace of each register-file write
  always_ff @(posedge clk) begin
    if (grf_we) begin
      $display("@%08h: $%2d <= %08h", grf_wpc, grf_waddr, grf_wdata);
    end
  end
`else
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter
//   Self-checking bench for grf_wb_arbiter (STARVE_MAX = 4). Directed steps
//   for reset, single write, starvation pattern, $0 write, same-address
//   ordering and mid-operation reset, followed by a randomized phase where
//   both requesters obey the hold-until-ack protocol. Expected values come
//   from a behavioural model: a priority rule with a wait counter, a
//   one-deep write pipeline and a shadow register file.
module tb_grf_wb_arbiter;

  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [4:0]  addr0 = 5'd0;
  logic [4:0]  addr1 = 5'd0;
  logic [31:0] data0 = 32'd0;
  logic [31:0] data1 = 32'd0;
  logic [31:0] pc0 = 32'd0;
  logic [31:0] pc1 = 32'd0;
  logic        ack0;
  logic        ack1;
  logic        stall0;
  logic        grf_we;
  logic [4:0]  grf_waddr;
  logic [31:0] grf_wdata;
  logic [31:0] grf_wpc;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int          mWait = 0;
  bit          e0, e1;
  bit          mWe = 1'b0;
  logic [4:0]  mAddr = 5'd0;
  logic [31:0] mData = 32'd0;
  logic [31:0] mPc = 32'd0;
  bit          mKnown = 1'b1;
  logic [31:0] mRf [32];
  logic [31:0] dRf [32];
  int          age1 = 0;
  logic        lastAck0 = 1'b0;
  logic        lastAck1 = 1'b0;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .pc0(pc0), .pc1(pc1),
    .ack0(ack0), .ack1(ack1), .stall0(stall0),
    .grf_we(grf_we), .grf_waddr(grf_waddr),
    .grf_wdata(grf_wdata), .grf_wpc(grf_wpc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Who should win this cycle: a port-1 request that has lost SM times in a
  // row is owed the slot; otherwise the pipeline port goes first.
  function automatic void predict(output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset) begin
      if (req1 && mWait >= SM) g1 = 1'b1;
      else if (req0)           g0 = 1'b1;
      else if (req1)           g1 = 1'b1;
    end
  endfunction

  // One clock cycle: inputs were set at posedge+1; check grant at posedge+3,
  // advance the model at the posedge, check the write port at posedge+1.
  task automatic step(input bit rstMid = 1'b0);
    #2;
    predict(e0, e1);
    lastAck0 = ack0;
    lastAck1 = ack1;
    check("ack0", ack0, e0);
    check("ack1", ack1, e1);
    check("stall0", stall0, req0 & ~e0);
    check("mutex", ack0 & ack1, 1'b0);
    if (reset && req1 && !ack1) age1++;
    else age1 = 0;
    check("starve_bound", age1 <= SM, 1'b1);
    if (rstMid) begin
      #1;
      reset = 1'b0;
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      mWe = 1'b0; mAddr = 5'd0; mData = 32'd0; mPc = 32'd0;
      mKnown = 1'b1; mWait = 0;
    end else begin
      if (req1 && !e1) mWait = (mWait < SM) ? mWait + 1 : SM;
      else mWait = 0;
      if (e0 || e1) begin
        mAddr  = e0 ? addr0 : addr1;
        mData  = e0 ? data0 : data1;
        mPc    = e0 ? pc0 : pc1;
        mWe    = (mAddr != 5'd0);
        mKnown = mWe;
      end else begin
        mWe = 1'b0;
      end
    end
    check("grf_we", grf_we, mWe);
    if (mKnown) begin
      check("grf_waddr", grf_waddr, mAddr);
      check("grf_wdata", grf_wdata, mData);
      check("grf_wpc", grf_wpc, mPc);
    end
    if (mWe) mRf[mAddr] = mData;
    if (grf_we === 1'b1) dRf[grf_waddr] = grf_wdata;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mRf[i] = 32'd0;
      dRf[i] = 32'd0;
    end

    // reset state with a pending request
    req0 = 1'b1; addr0 = 5'd3; data0 = 32'h33;
    #12;
    check("rst_ack0", ack0, 1'b0);
    check("rst_ack1", ack1, 1'b0);
    check("rst_stall0", stall0, 1'b1);
    check("rst_we", grf_we, 1'b0);
    check("rst_waddr", grf_waddr, 5'd0);
    check("rst_wdata", grf_wdata, 32'd0);
    check("rst_wpc", grf_wpc, 32'd0);
    req0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // single port-0 write, first cycle after reset release
    req0 = 1'b1; addr0 = 5'd5; data0 = 32'h1234; pc0 = 32'h100;
    step();
    check("w0_ack0", lastAck0, 1'b1);
    check("w0_we", grf_we, 1'b1);
    check("w0_waddr", grf_waddr, 5'd5);
    check("w0_wdata", grf_wdata, 32'h0000_1234);
    req0 = 1'b0;
    step();
    check("w0_we_drop", grf_we, 1'b0);
    check("w0_hold", grf_wdata, 32'h0000_1234);

    // both held: 4 port-0 grants then one port-1 grant, repeating
    req0 = 1'b1; addr0 = 5'd9;  data0 = 32'hA0; pc0 = 32'h200;
    req1 = 1'b1; addr1 = 5'd10; data1 = 32'hB1; pc1 = 32'h300;
    for (int c = 0; c < 10; c++) begin
      step();
      check("pat_ack1", lastAck1, (c % 5 == 4) ? 1'b1 : 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // port 1 alone writing $0: acked, no write enable
    req1 = 1'b1; addr1 = 5'd0; data1 = 32'hDEAD; pc1 = 32'h400;
    step();
    check("z_ack1", lastAck1, 1'b1);
    check("z_we", grf_we, 1'b0);
    req1 = 1'b0;
    step();

    // same address from both ports: port 0 lands first, port 1 persists
    req0 = 1'b1; addr0 = 5'd7; data0 = 32'hA; pc0 = 32'h500;
    req1 = 1'b1; addr1 = 5'd7; data1 = 32'hB; pc1 = 32'h504;
    step();
    check("same_first", grf_wdata, 32'hA);
    req0 = 1'b0;
    step();
    check("same_second", grf_wdata, 32'hB);
    check("same_we", grf_we, 1'b1);
    req1 = 1'b0;
    step();
    check("rf7", dRf[7], 32'hB);

    // reset right after an ack discards the captured write
    req0 = 1'b1; addr0 = 5'd4; data0 = 32'h44; pc0 = 32'h600;
    step(1'b1);
    check("rr_we", grf_we, 1'b0);
    check("rr_wdata", grf_wdata, 32'd0);
    step();
    reset = 1'b1;
    step();
    check("rr_reack", lastAck0, 1'b1);
    req0 = 1'b0;
    step();
    check("rr_wdata2", grf_wdata, 32'h44);

    // randomized traffic obeying hold-until-ack
    for (int c = 0; c < 400; c++) begin
      if (!req0 || lastAck0) begin
        req0  = ($urandom_range(0, 3) != 0);
        addr0 = 5'($urandom_range(0, 31));
        data0 = $urandom;
        pc0   = $urandom;
      end
      if (!req1 || lastAck1) begin
        req1  = ($urandom_range(0, 1) != 0);
        addr1 = 5'($urandom_range(0, 31));
        data1 = $urandom;
        pc1   = $urandom;
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    for (int i = 1; i < 32; i++) begin
      check("rf_final", dRf[i], mRf[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grf_wb_arbiter.md
GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4: the number of consecutive cycles port 1 may wait while port 0 is granted before port 1 is forced to win.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0 and req1, input, 1 bit each: writeback request from port 0 (main pipeline) and port 1 (multi-cycle unit).
REQ-005 The block SHALL have ports addr0 and addr1, input, 5 bits each: destination register of each port.
REQ-006 The block SHALL have ports data0 and data1, input, 32 bits each: write data of each port.
REQ-007 The block SHALL have ports pc0 and pc1, input, 32 bits each: PC of the writing instruction on each port.
REQ-008 The block SHALL have ports ack0 and ack1, output, 1 bit each: combinational grant; the request is consumed in the cycle where ack is high.
REQ-009 The block SHALL have port stall0, output, 1 bit: equal to req0 AND NOT ack0, used to freeze the pipeline.
REQ-010 The block SHALL have ports grf_we (1 bit), grf_waddr (5 bits), grf_wdata (32 bits) and grf_wpc (32 bits), all outputs, registered: the register-file write port.

Function
REQ-011 Requester SHALL hold req and its payload stable until ack is seen; ack0 and ack1 SHALL never both be high in one cycle.
REQ-012 Grant rule: if req1 && wait_cnt==STARVE_MAX, ack1; else if req0, ack0; else if req1, ack1; else no ack.
REQ-013 wait_cnt (width clog2(STARVE_MAX+1)) SHALL increment when req1 && !ack1, saturating at STARVE_MAX, and SHALL clear to 0 on ack1 or when req1 is low.
REQ-014 On an acked cycle the output stage SHALL capture the granted addr/data/pc on the next posedge; grf_we SHALL be high exactly one cycle, one cycle after ack (latency 1).
REQ-015 An acked request with addr==0 SHALL still be acked, but grf_we SHALL stay 0 for it; the captured address/data are don't-care.
REQ-016 With no ack in a cycle, grf_we SHALL be 0 the next cycle and grf_waddr/grf_wdata/grf_wpc SHALL hold their previous values.
REQ-017 Back-to-back grants SHALL be allowed: sustained requests yield one write per cycle with no bubble.
REQ-018 If both ports request the same address simultaneously, port 0's write SHALL land first (unless starvation forces port 1), so the later grant's value persists; the block SHALL not merge or drop either write.
REQ-019 Throughput guarantee: port 1 SHALL be acked at most STARVE_MAX+1 cycles after raising req1.

Reset
REQ-020 While reset==0: grf_we=0, grf_waddr=0, grf_wdata=0, grf_wpc=0, wait_cnt=0, ack0=ack1=0, stall0=req0.
REQ-021 Reset asserted mid-operation SHALL discard any captured-but-unwritten entry (no grf_we after release for it); pending requests SHALL be re-arbitrated from wait_cnt=0 after release.
REQ-022 The first ack SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-023 Macro GRF_WB_TRACE_EN: when defined, each cycle with grf_we==1 SHALL print "@<pc hex8>: $<addr dec2> <= <data hex8>" in simulation; when undefined, no display code SHALL be compiled, and function SHALL be identical.

Verification
REQ-024 Only req0=1, addr0=5, data0=0x1234 -> ack0 same cycle; next cycle grf_we=1, grf_waddr=5, grf_wdata=0x00001234.
REQ-025 req0 and req1 held high continuously, STARVE_MAX=4 -> ack0 for 4 cycles, then ack1 in the 5th; wait_cnt back to 0; pattern repeats.
REQ-026 req1 only, addr1=0 -> ack1 high; grf_we stays 0 on the following cycle.
REQ-027 Both request addr 7 (data0=0xA, data1=0xB) -> writes 0xA then 0xB on consecutive cycles; final register value is 0xB.
REQ-028 reset pulsed low in the cycle after ack0 -> no grf_we pulse; all outputs 0; req0 still high is re-acked in the first cycle after release.
REQ-029 Build with GRF_WB_TRACE_EN, write pc=0x3000, addr=2, data=0xFF -> log line "@00003000: $ 2 <= 000000ff".
